// File: rtl/gf180mcu_fd_sc_mcu7t5v0__xnor3_parity_arb.sv
// Two-client XNOR-parity scheduler; grant-to-VLD latency WIDTH/2 cycles, REQ held until GNT (ignored while BUSY).
// Round-robin arbitration when GF180MCU_FD_SC_MCU7T5V0__XNOR3_PARITY_ARB_RR_EN is defined, else REQ0 has fixed priority.
module gf180mcu_fd_sc_mcu7t5v0__xnor3_parity_arb #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RN,
  input  logic             REQ0,
  input  logic [WIDTH-1:0] D0,
  input  logic             REQ1,
  input  logic [WIDTH-1:0] D1,
  output logic             GNT0,
  output logic             GNT1,
  output logic             BUSY,
  output logic             VLD,
  output logic             ID,
  output logic             ZN
);

  localparam int CNT_W = (WIDTH / 2 > 1) ? $clog2(WIDTH / 2) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH / 2 - 1);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic             acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             gnt0_q, gnt0_d;
  logic             gnt1_q, gnt1_d;
  logic             busy_q, busy_d;
  logic             vld_q, vld_d;
  logic             id_q, id_d;
  logic             zn_q, zn_d;

  logic any_req;
  logic win1;
  logic last_fold;
  logic fold;

`ifdef GF180MCU_FD_SC_MCU7T5V0__XNOR3_PARITY_ARB_RR_EN
  logic ptr_q, ptr_d;

  // On contention the pointer picks; a lone requester always wins.
  assign win1 = REQ1 & (~REQ0 | ptr_q);

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) ptr_q <= 1'b0;
    else     ptr_q <= ptr_d;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (state_q == IDLE && any_req) ptr_d = ~win1;
  end
`else
  assign win1 = REQ1 & ~REQ0;
`endif

  assign any_req   = REQ0 | REQ1;
  assign last_fold = (cnt_q == LAST_CNT);
  // Shared XNOR3 stage, kept in true-parity form so ACC starts at 0.
  assign fold      = acc_q ^ sr_q[1] ^ sr_q[0];

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state_q <= IDLE;
      sr_q    <= '0;
      acc_q   <= 1'b0;
      cnt_q   <= '0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      busy_q  <= 1'b0;
      vld_q   <= 1'b0;
      id_q    <= 1'b0;
      zn_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      busy_q  <= busy_d;
      vld_q   <= vld_d;
      id_q    <= id_d;
      zn_q    <= zn_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = RUN;
      RUN:     if (last_fold) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sr_d   = sr_q;
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    gnt0_d = 1'b0;
    gnt1_d = 1'b0;
    vld_d  = 1'b0;
    id_d   = id_q;
    zn_d   = zn_q;
    busy_d = (state_d == RUN);
    case (state_q)
      IDLE: begin
        if (any_req) begin
          sr_d   = win1 ? D1 : D0;
          acc_d  = 1'b0;
          cnt_d  = '0;
          id_d   = win1;
          gnt0_d = ~win1;
          gnt1_d = win1;
        end
      end
      RUN: begin
        acc_d = fold;
        sr_d  = sr_q >> 2;
        cnt_d = cnt_q + CNT_W'(1);
        if (last_fold) begin
          zn_d  = ~fold;
          vld_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign GNT0 = gnt0_q;
  assign GNT1 = gnt1_q;
  assign BUSY = busy_q;
  assign VLD  = vld_q;
  assign ID   = id_q;
  assign ZN   = zn_q;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__xnor3_parity_arb.sv
// Randomized and directed checks of the parity scheduler against a job-level reference model.
module tb_gf180mcu_fd_sc_mcu7t5v0__xnor3_parity_arb;

  localparam int W = 8;

  logic         CLK = 1'b0;
  logic         RN;
  logic         req0, req1;
  logic [W-1:0] d0, d1;
  logic         gnt0, gnt1, busy, vld, id, zn;

  logic         b_req0, b_req1;
  logic [1:0]   b_d0, b_d1;
  logic         b_gnt0, b_gnt1, b_busy, b_vld, b_id, b_zn;

  always #5 CLK = ~CLK;

  gf180mcu_fd_sc_mcu7t5v0__xnor3_parity_arb #(.WIDTH(W)) u_dut (
    .CLK(CLK), .RN(RN), .REQ0(req0), .D0(d0), .REQ1(req1), .D1(d1),
    .GNT0(gnt0), .GNT1(gnt1), .BUSY(busy), .VLD(vld), .ID(id), .ZN(zn)
  );

  gf180mcu_fd_sc_mcu7t5v0__xnor3_parity_arb #(.WIDTH(2)) u_dut_w2 (
    .CLK(CLK), .RN(RN), .REQ0(b_req0), .D0(b_d0), .REQ1(b_req1), .D1(b_d1),
    .GNT0(b_gnt0), .GNT1(b_gnt1), .BUSY(b_busy), .VLD(b_vld), .ID(b_id), .ZN(b_zn)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, expv, $time);
    end
  endtask

  // Reference model: a job is a countdown of WIDTH/2 cycles whose result is the even-ones test of the word.
  int           m_left = 0;
  logic         m_ptr  = 1'b0;
  logic         m_id   = 1'b0;
  logic         m_zn   = 1'b1;
  logic [W-1:0] m_word = '0;
  logic         e_g0 = 1'b0, e_g1 = 1'b0, e_vld = 1'b0;
  int           cyc = 0, last_gnt = 0, last_vld = 0;
  int           gnt_seq[$];

  task automatic step();
    logic w;
    e_g0 = 1'b0; e_g1 = 1'b0; e_vld = 1'b0;
    if (!RN) begin
      m_left = 0; m_ptr = 1'b0; m_id = 1'b0; m_zn = 1'b1;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        e_vld = 1'b1;
        m_zn  = ($countones(m_word) % 2 == 0);
      end
    end else if (req0 || req1) begin
`ifdef GF180MCU_FD_SC_MCU7T5V0__XNOR3_PARITY_ARB_RR_EN
      w = (req0 && req1) ? m_ptr : req1;
      m_ptr = ~w;
`else
      w = req1 && !req0;
`endif
      m_word = w ? d1 : d0;
      m_id   = w;
      e_g0   = ~w;
      e_g1   = w;
      m_left = W / 2;
    end
    @(posedge CLK);
    @(negedge CLK);
    cyc++;
    chk("gnt0", gnt0, e_g0);
    chk("gnt1", gnt1, e_g1);
    chk("busy", busy, m_left > 0);
    chk("vld",  vld,  e_vld);
    chk("id",   id,   m_id);
    chk("zn",   zn,   m_zn);
    if (gnt0 || gnt1) begin
      last_gnt = cyc;
      gnt_seq.push_back(gnt1 ? 1 : 0);
    end
    if (vld) last_vld = cyc;
  endtask

  task automatic idle_until_done();
    for (int i = 0; i < W; i++) step();
  endtask

  initial begin
    RN = 1'b0; req0 = 1'b0; req1 = 1'b0; d0 = '0; d1 = '0;
    b_req0 = 1'b0; b_req1 = 1'b0; b_d0 = '0; b_d1 = '0;

    // Reset held with requests toggling.
    for (int i = 0; i < 4; i++) begin
      req0 = i[0]; req1 = ~i[0]; d0 = 8'($urandom); d1 = 8'($urandom);
      step();
    end
    req0 = 1'b0; req1 = 1'b0;
    RN = 1'b1;
    step();

    // Even parity on client 0.
    req0 = 1'b1; d0 = 8'hA5;
    step();
    chk("a5_gnt", gnt0, 1);
    req0 = 1'b0;
    idle_until_done();
    chk("a5_lat", last_vld - last_gnt, W / 2);
    chk("a5_zn", zn, 1);
    chk("a5_id", id, 0);

    // Odd parity on client 1.
    req1 = 1'b1; d1 = 8'h07;
    step();
    chk("07_gnt", gnt1, 1);
    req1 = 1'b0;
    idle_until_done();
    chk("07_lat", last_vld - last_gnt, W / 2);
    chk("07_zn", zn, 0);
    chk("07_id", id, 1);

    // Both clients requesting continuously.
    gnt_seq.delete();
    req0 = 1'b1; req1 = 1'b1; d0 = 8'hFF; d1 = 8'h01;
    for (int i = 0; i < 4 * (W / 2 + 1); i++) step();
    req0 = 1'b0; req1 = 1'b0;
    idle_until_done();
    chk("cont_ngnt", gnt_seq.size(), 4);
    for (int i = 0; i < gnt_seq.size(); i++) begin
`ifdef GF180MCU_FD_SC_MCU7T5V0__XNOR3_PARITY_ARB_RR_EN
      chk("cont_order", gnt_seq[i], i % 2);
`else
      chk("cont_order", gnt_seq[i], 0);
`endif
    end

    // Reset in the middle of a job, with client 1 waiting.
    req0 = 1'b1; d0 = 8'h01;
    step();
    req0 = 1'b0;
    step();
    req1 = 1'b1; d1 = 8'h03;
    step();
    RN = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_zn", zn, 1);
    step();
    chk("abort_vld", vld, 0);
    RN = 1'b1;
    step();
    chk("abort_regnt", gnt1, 1);
    req1 = 1'b0;
    idle_until_done();
    chk("abort_zn2", zn, 1);

    // Random traffic obeying the request protocol.
    for (int i = 0; i < 400; i++) begin
      step();
      if (req0 && e_g0) req0 = 1'b0;
      else if (!req0 && $urandom_range(0, 2) == 0) begin req0 = 1'b1; d0 = 8'($urandom); end
      if (req1 && e_g1) req1 = 1'b0;
      else if (!req1 && $urandom_range(0, 2) == 0) begin req1 = 1'b1; d1 = 8'($urandom); end
    end
    req0 = 1'b0; req1 = 1'b0;
    idle_until_done();

    // Two-bit word: one fold, then an immediate follow-on grant.
    b_req0 = 1'b1; b_d0 = 2'b10;
    @(posedge CLK); @(negedge CLK);
    chk("w2_gnt", b_gnt0, 1);
    chk("w2_busy", b_busy, 1);
    @(posedge CLK); @(negedge CLK);
    chk("w2_vld", b_vld, 1);
    chk("w2_zn", b_zn, 0);
    chk("w2_busy_lo", b_busy, 0);
    chk("w2_gnt_lo", b_gnt0, 0);
    @(posedge CLK); @(negedge CLK);
    chk("w2_b2b_gnt", b_gnt0, 1);
    chk("w2_b2b_vld", b_vld, 0);
    b_req0 = 1'b0; b_d0 = 2'b11;
    @(posedge CLK); @(negedge CLK);
    chk("w2_vld2", b_vld, 1);
    chk("w2_zn2", b_zn, 0);
    b_req1 = 1'b1; b_d1 = 2'b11;
    @(posedge CLK); @(negedge CLK);
    chk("w2_gnt1", b_gnt1, 1);
    chk("w2_id1", b_id, 1);
    b_req1 = 1'b0;
    @(posedge CLK); @(negedge CLK);
    chk("w2_zn3", b_zn, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
